requant_dither_pack: RTL and testbench
======================================

# requant_dither_pack

Stochastic requantizer and packer sitting directly downstream of the 64-bit random-bit generator. Takes signed complex baseband samples, adds uniform dither from the generator's output, truncates to `OUT_W` bits per component with saturation, and packs the results into 64-bit words for the capture/Ethernet path. It also drives the generator's clock enable, so exactly one fresh random word is consumed per accepted sample.

## Interface
- `IN_W`, 8, input component width (signed two's complement)
- `OUT_W`, 4, output component width. Legal range is 1 ≤ `OUT_W` < `IN_W`, and 2·`OUT_W` must divide 64.
- `SAT_W`, 16, width of the saturation counter
- `clk` input 1: single clock for the block and for the RNG
- `reset` input 1: synchronous, active-high
- `in_valid` input 1: sample strobe; no backpressure
- `in_i` input `IN_W`: in-phase sample
- `in_q` input `IN_W`: quadrature sample
- `rng` input 64: random word from the generator
- `rng_ce` output 1: clock enable to the generator
- `sat_clear` input 1: clears `sat_count`
- `out_valid` output 1: one-cycle pulse when a packed word completes
- `out_data` output 64: packed word, held until the next word completes
- `sat_count` output `SAT_W`: saturated-component count; sticks at all-ones

## Operation
- Dither width is D = `IN_W` − `OUT_W`.
  - I dither is `rng[D-1:0]`, treated as unsigned.
  - Q dither is `rng[2D-1:D]`.
- `rng_ce` = `in_valid` & ~`reset`, combinational. The sample uses the `rng` value present in its accept cycle; the generator advances for the next sample.
- Per component, in the accept cycle (stage 1):
  - sum = sign-extend(x, `IN_W`+1) + zero-extend(dither).
  - The sum is registered.
- Stage 2:
  - y = sum >>> D (arithmetic shift, i.e. floor).
  - Saturate y to [−2^(`OUT_W`−1), 2^(`OUT_W`−1)−1].
  - The result is registered, together with a per-component saturation flag.
- Packing:
  - Samples per word N = 64 / (2·`OUT_W`).
  - Sample k occupies bits [2·`OUT_W`·k +: 2·`OUT_W`]. I is in the low `OUT_W` bits of that field, Q in the high `OUT_W` bits.
  - A counter runs 0…N−1 and wraps. Sample 0 is the first sample after reset.
  - When sample N−1 lands, the full word is transferred to `out_data` and `out_valid` pulses.
- Saturation counter:
  - Adds 0, 1 or 2 per stage-2 sample (the I flag plus the Q flag).
  - Saturates at 2^`SAT_W`−1 and never wraps.
  - `sat_clear` has priority: when it is asserted, the result is 0 and that cycle's increments are discarded.
- Gaps in `in_valid` stall nothing; pipeline valid bits simply carry zeros.

## Timing
- Sample accepted at cycle t:
  - the stage-1 register holds it at t+1;
  - the stage-2 register holds it at t+2;
  - it is written into the pack register at t+3.
- `out_valid` is high in cycle t+3 for the sample that completes a word; `out_data` is valid in that same cycle.
- Back-to-back `in_valid` is sustained at full rate.
  - With `OUT_W`=4, one word completes every 8 accepted samples.
  - With `OUT_W`=2, one word completes every 16.
- Reset values: `out_valid`=0, `out_data`=0, `sat_count`=0, `rng_ce`=0.
  - Pipeline valid bits and the pack counter clear to 0.
  - The partial pack register is cleared.
- Reset mid-word: in-flight and partially packed samples are discarded. The first sample accepted after reset deasserts becomes sample 0.
- `in_valid` asserted together with `reset`: the sample is dropped and `rng_ce` stays 0.

## Structure
- Shared package: `RNG_W`=64, `WORD_W`=64, and a function computing samples-per-word from `OUT_W`.
- Sub-module `requant_lane`, instantiated twice (I and Q):
  - holds the dither add, the stage-1 register, the shift and saturate, and the stage-2 register;
  - outputs the `OUT_W` value plus the saturation flag.
- The top level holds the pack counter, pack register, output register, saturation counter and `rng_ce`.

## Test plan
- Rounding: `OUT_W`=4; bench drives `rng` directly. All of the following come out at t+2 with no `sat_count` change:
  - `in_i`=0x10, dither 0 → 1
  - `in_i`=0x10, dither 0xF → 1
  - `in_i`=0x1F, dither 1 → 2
  - `in_i`=0xF0, dither 0 → −1 (0xF)
- Saturation:
  - `in_i`=0x7F, dither 0xF (sum 142) → 7; `sat_count` increments by 1.
  - `in_i`=0x7F and `in_q`=0x7F, both dithers 0xF → `sat_count` increments by 2.
  - `sat_clear` held together with a saturating sample → `sat_count`=0.
- Packing:
  - 8 back-to-back samples with I=k, Q=0 and `rng`=0 → one `out_valid` pulse, 3 cycles after the 8th accept, with `out_data`=0x0706050403020100.
  - 16 samples → two pulses 8 cycles apart.
- Gaps and `rng_ce`:
  - Random `in_valid` gaps → `rng_ce` mirrors `in_valid` exactly.
  - Word contents match a reference model that uses the `rng` value seen in each accept cycle.
- Reset mid-word: 3 samples, then a 1-cycle `reset`, then 8 samples → exactly one pulse, containing only the post-reset samples.
  - The pulse arrives 3 cycles after the 8th post-reset accept.
  - During reset, all outputs read 0.
- Counter limit: force `SAT_W`=4 and feed 20 saturating components → `sat_count` holds at 0xF.

Source files
------------

// File: rtl/requant_dither_pack_pkg.sv
// Shared constants for the requantizer/packer: generator and output word widths,
// plus the samples-per-word helper used to size the pack counter.
package requant_dither_pack_pkg;

    localparam int RNG_W  = 64;
    localparam int WORD_W = 64;

    function automatic int samples_per_word(input int out_w);
        return WORD_W / (2 * out_w);
    endfunction

endpackage

// File: rtl/requant_dither_pack_lane.sv
// One component lane: dither add into stage 1, then floor-shift and saturate into stage 2.
module requant_lane #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [IN_W-1:0]         x,
    input  logic [IN_W-OUT_W-1:0]   dither,
    output logic [OUT_W-1:0]        y,
    output logic                    sat
);

    localparam int D = IN_W - OUT_W;
    localparam logic signed [IN_W:0] SAT_MAX = (IN_W+1)'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [IN_W:0] SAT_MIN = (IN_W+1)'(-(2 ** (OUT_W - 1)));

    logic signed [IN_W:0] sum_r;
    logic signed [IN_W:0] shifted;
    logic [OUT_W-1:0]     y_next;
    logic                 sat_next;

    // The sum is one bit wider than the sample so the largest dither never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_r <= '0;
        end else if (load) begin
            sum_r <= {x[IN_W-1], x} + {{(OUT_W+1){1'b0}}, dither};
        end
    end

    assign shifted = sum_r >>> D;

    always_comb begin
        y_next   = shifted[OUT_W-1:0];
        sat_next = 1'b0;
        if (shifted > SAT_MAX) begin
            y_next   = SAT_MAX[OUT_W-1:0];
            sat_next = 1'b1;
        end else if (shifted < SAT_MIN) begin
            y_next   = SAT_MIN[OUT_W-1:0];
            sat_next = 1'b1;
        end
    end

    // Stage 2 tracks stage 1 every cycle; the top level qualifies it with its valid bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            y   <= '0;
            sat <= 1'b0;
        end else begin
            y   <= y_next;
            sat <= sat_next;
        end
    end

endmodule

// File: rtl/requant_dither_pack.sv
// Dithered requantizer for complex samples, packing I/Q pairs into 64-bit words and
// counting saturated components. Drives the random generator's clock enable.
module requant_dither_pack
    import requant_dither_pack_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 4,
    parameter int SAT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [IN_W-1:0]   in_i,
    input  logic [IN_W-1:0]   in_q,
    input  logic [RNG_W-1:0]  rng,
    output logic              rng_ce,
    input  logic              sat_clear,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic [SAT_W-1:0]  sat_count
);

    localparam int D       = IN_W - OUT_W;
    localparam int N       = samples_per_word(OUT_W);
    localparam int CNT_W   = (N > 1) ? $clog2(N) : 1;
    localparam int FIELD_W = 2 * OUT_W;

    logic               v1;
    logic               v2;
    logic [CNT_W-1:0]   cnt;
    logic [WORD_W-1:0]  pack_r;
    logic [WORD_W-1:0]  next_word;
    logic [OUT_W-1:0]   i_y;
    logic [OUT_W-1:0]   q_y;
    logic               i_sat;
    logic               q_sat;
    logic [1:0]         sat_inc;
    logic [SAT_W:0]     sat_sum;
    logic [SAT_W-1:0]   sat_next;

    assign rng_ce = in_valid & ~reset;

    generate
        if (2 * D < RNG_W) begin : g_rng_spare
            logic unused_rng;
            assign unused_rng = ^rng[RNG_W-1:2*D];
        end
    endgenerate

    requant_lane #(.IN_W(IN_W), .OUT_W(OUT_W)) u_lane_i (
        .clk    (clk),
        .reset  (reset),
        .load   (rng_ce),
        .x      (in_i),
        .dither (rng[D-1:0]),
        .y      (i_y),
        .sat    (i_sat)
    );

    requant_lane #(.IN_W(IN_W), .OUT_W(OUT_W)) u_lane_q (
        .clk    (clk),
        .reset  (reset),
        .load   (rng_ce),
        .x      (in_q),
        .dither (rng[2*D-1:D]),
        .y      (q_y),
        .sat    (q_sat)
    );

    always_comb begin
        next_word = pack_r;
        next_word[FIELD_W*cnt +: FIELD_W] = {q_y, i_y};
    end

    // Counter sticks at all-ones: the carry out of the add selects the saturated value.
    assign sat_inc  = {1'b0, v2 & i_sat} + {1'b0, v2 & q_sat};
    assign sat_sum  = {1'b0, sat_count} + (SAT_W+1)'(sat_inc);
    assign sat_next = sat_sum[SAT_W] ? '1 : sat_sum[SAT_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            cnt       <= '0;
            pack_r    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            sat_count <= '0;
        end else begin
            v1        <= rng_ce;
            v2        <= v1;
            out_valid <= 1'b0;
            if (v2) begin
                pack_r <= next_word;
                if (cnt == CNT_W'(N - 1)) begin
                    out_data  <= next_word;
                    out_valid <= 1'b1;
                    cnt       <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            sat_count <= sat_clear ? '0 : sat_next;
        end
    end

endmodule

// File: tb/tb_requant_dither_pack.sv
// Scoreboard bench: each driven sample updates an integer reference model; completed
// words are queued with their expected arrival cycle and matched when out_valid pulses.
module tb_requant_dither_pack;

    localparam int IN_W    = 8;
    localparam int OUT_W   = 4;
    localparam int D       = IN_W - OUT_W;
    localparam int N       = 64 / (2 * OUT_W);
    localparam int FIELD_W = 2 * OUT_W;
    localparam int Y_MAX   = (2 ** (OUT_W - 1)) - 1;
    localparam int Y_MIN   = -(2 ** (OUT_W - 1));

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_i;
    logic [7:0]  in_q;
    logic [63:0] rng;
    logic        sat_clear;
    logic        rng_ce;
    logic        out_valid;
    logic [63:0] out_data;
    logic [15:0] sat_count;
    logic        rng_ce_s4;
    logic        out_valid_s4;
    logic [63:0] out_data_s4;
    logic [3:0]  sat_count_s4;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    exp_t        exp_q[$];
    logic [63:0] m_word;
    int          m_idx;
    int          m_sat;
    int          m_sat4;

    requant_dither_pack #(.IN_W(IN_W), .OUT_W(OUT_W), .SAT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_i      (in_i),
        .in_q      (in_q),
        .rng       (rng),
        .rng_ce    (rng_ce),
        .sat_clear (sat_clear),
        .out_valid (out_valid),
        .out_data  (out_data),
        .sat_count (sat_count)
    );

    requant_dither_pack #(.IN_W(IN_W), .OUT_W(OUT_W), .SAT_W(4)) dut_s4 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_i      (in_i),
        .in_q      (in_q),
        .rng       (rng),
        .rng_ce    (rng_ce_s4),
        .sat_clear (sat_clear),
        .out_valid (out_valid_s4),
        .out_data  (out_data_s4),
        .sat_count (sat_count_s4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Returns {sat_flag, y} for one component using plain integer arithmetic.
    function automatic logic [OUT_W:0] model_lane(input logic [7:0] x, input logic [D-1:0] d);
        int s;
        int y;
        logic sat;
        logic [OUT_W-1:0] yv;
        s   = int'($signed(x)) + int'(d);
        y   = s >>> D;
        sat = 1'b0;
        if (y > Y_MAX) begin
            y = Y_MAX;
            sat = 1'b1;
        end else if (y < Y_MIN) begin
            y = Y_MIN;
            sat = 1'b1;
        end
        yv = y[OUT_W-1:0];
        return {sat, yv};
    endfunction

    task automatic applyStimulus(input logic v, input logic [7:0] i, input logic [7:0] q,
                                 input logic [63:0] r);
        logic [OUT_W:0] li;
        logic [OUT_W:0] lq;
        int inc;
        in_valid = v;
        in_i     = i;
        in_q     = q;
        rng      = r;
        if (v && !reset) begin
            li = model_lane(i, r[D-1:0]);
            lq = model_lane(q, r[2*D-1:D]);
            m_word[FIELD_W*m_idx +: FIELD_W] = {lq[OUT_W-1:0], li[OUT_W-1:0]};
            inc    = int'(li[OUT_W]) + int'(lq[OUT_W]);
            m_sat  = (m_sat + inc > 65535) ? 65535 : m_sat + inc;
            m_sat4 = (m_sat4 + inc > 15) ? 15 : m_sat4 + inc;
            m_idx++;
            if (m_idx == N) begin
                exp_q.push_back('{data: m_word, cyc: cyc + 3});
                m_idx = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 8'h00, 8'h00, {$urandom, $urandom});
    endtask

    task automatic padWord();
        while (m_idx != 0)
            applyStimulus(1'b1, 8'($urandom), 8'($urandom), {$urandom, $urandom});
    endtask

    // One-cycle reset with a sample offered at the same time; that sample must be dropped.
    task automatic applyReset();
        reset    = 1'b1;
        in_valid = 1'b1;
        in_i     = 8'h7F;
        in_q     = 8'h7F;
        rng      = 64'hFF;
        @(negedge clk);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_data", out_data, 64'd0);
        checkOutput("rst_sat_count", 64'(sat_count), 64'd0);
        checkOutput("rst_rng_ce", 64'(rng_ce), 64'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        m_word   = '0;
        m_idx    = 0;
        m_sat    = 0;
        m_sat4   = 0;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        checkOutput("rng_ce_mirror", 64'(rng_ce), 64'(in_valid & ~reset));
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_word", out_data, 64'hDEAD_DEAD_DEAD_DEAD);
            end else begin
                e = exp_q.pop_front();
                checkOutput("word_data", out_data, e.data);
                checkOutput("word_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_i      = '0;
        in_q      = '0;
        rng       = '0;
        sat_clear = 1'b0;
        m_word    = '0;
        m_idx     = 0;
        m_sat     = 0;
        m_sat4    = 0;
        repeat (2) @(negedge clk);
        checkOutput("init_out_valid", 64'(out_valid), 64'd0);
        checkOutput("init_out_data", out_data, 64'd0);
        checkOutput("init_sat_count", 64'(sat_count), 64'd0);
        reset = 1'b0;
        idle(2);

        // Packing: I = k, Q = 0, no dither; then a second word to check pulse spacing.
        for (int k = 0; k < 8; k++) applyStimulus(1'b1, 8'(k * 16), 8'h00, 64'h0);
        for (int k = 0; k < 8; k++) applyStimulus(1'b1, 8'(k * 16 + 15), 8'h00, 64'h0);
        idle(5);

        // Rounding cases, none saturating.
        applyStimulus(1'b1, 8'h10, 8'h00, 64'h0);
        applyStimulus(1'b1, 8'h10, 8'h00, 64'hF);
        applyStimulus(1'b1, 8'h1F, 8'h00, 64'h1);
        applyStimulus(1'b1, 8'hF0, 8'h00, 64'h0);
        idle(4);
        checkOutput("round_sat_count", 64'(sat_count), 64'(m_sat));

        // Saturation: one component, then both components.
        applyStimulus(1'b1, 8'h7F, 8'h00, 64'h0F);
        idle(4);
        checkOutput("sat_one", 64'(sat_count), 64'(m_sat));
        applyStimulus(1'b1, 8'h7F, 8'h7F, 64'hFF);
        idle(4);
        checkOutput("sat_two", 64'(sat_count), 64'(m_sat));

        sat_clear = 1'b1;
        applyStimulus(1'b1, 8'h7F, 8'h7F, 64'hFF);
        idle(4);
        sat_clear = 1'b0;
        m_sat  = 0;
        m_sat4 = 0;
        checkOutput("sat_clear", 64'(sat_count), 64'd0);
        checkOutput("sat_clear_s4", 64'(sat_count_s4), 64'd0);

        // Twenty saturating components: the 4-bit counter must stick at 0xF.
        for (int k = 0; k < 10; k++) applyStimulus(1'b1, 8'h7F, 8'h7F, 64'hFF);
        idle(4);
        checkOutput("sat_limit_s4", 64'(sat_count_s4), 64'(m_sat4));
        checkOutput("sat_limit_wide", 64'(sat_count), 64'(m_sat));
        padWord();
        idle(5);

        // Random gaps with random data and random generator words.
        for (int k = 0; k < 200; k++)
            applyStimulus($urandom_range(0, 2) != 0, 8'($urandom), 8'($urandom),
                          {$urandom, $urandom});
        padWord();
        idle(5);
        checkOutput("gap_sat_count", 64'(sat_count), 64'(m_sat));

        // Reset mid-word: three samples are discarded, the next eight form the word.
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 8'h55, 8'hAA, 64'h3C);
        applyReset();
        for (int k = 0; k < 8; k++)
            applyStimulus(1'b1, 8'($urandom), 8'($urandom), {$urandom, $urandom});
        idle(6);

        checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
